// File: rtl/pll_rstseq_pkg.sv
// Shared definitions for pll_reset_sequencer: sequencer state encoding and counter sizing.
package pll_rstseq_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } rstseq_state_e;

  // Bits needed for a counter that spans 0..count-1, never less than one.
  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Generic STAGES-deep single-bit synchroniser with asynchronous active-low reset (output resets to 0).
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: lock filtering, reset stretch, staggered domain release and lock-loss capture.
// Define PLL_RSTSEQ_LOSS_CNT_EN to add the saturating loss_count port and counter.
module pll_reset_sequencer
  import pll_rstseq_pkg::*;
#(
  parameter int NUM_DOMAINS        = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int STRETCH_CYCLES     = 16,
  parameter int LOCK_FILTER_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 4
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  , parameter int LOSS_CNT_W       = 8
`endif
) (
  input  logic                   clock_in,
  input  logic                   rst_n_in,
  input  logic                   pll_lock_in,
  input  logic                   soft_rst_in,
  output logic [NUM_DOMAINS-1:0] domain_rst_out,
  output logic                   locked,
  output logic                   lock_lost
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  , output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

  localparam int REL_LAST   = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int SPAN_SF    = (STRETCH_CYCLES > LOCK_FILTER_CYCLES) ? STRETCH_CYCLES : LOCK_FILTER_CYCLES;
  localparam int CNT_SPAN   = (SPAN_SF > REL_LAST + 1) ? SPAN_SF : REL_LAST + 1;
  localparam int CW         = cnt_width(CNT_SPAN);
  localparam logic [CW-1:0] STRETCH_END = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] FILTER_END  = CW'(LOCK_FILTER_CYCLES - 1);
  // RUN is entered on the cycle the last domain would reach its release slot.
  localparam logic [CW-1:0] RELEASE_END = CW'((REL_LAST > 0) ? REL_LAST - 1 : 0);

  logic                   lock_s;
  rstseq_state_e          state_r, state_next_s;
  logic [CW-1:0]          cnt_r, cnt_next_s;
  logic                   loss_s;
  logic [NUM_DOMAINS-1:0] rst_next_s;

  lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clock_in),
    .rst_n (rst_n_in),
    .d     (pll_lock_in),
    .q     (lock_s)
  );

  // Next-state, shared phase counter and lock-loss decode; soft reset overrides a simultaneous loss.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    loss_s       = 1'b0;
    if (soft_rst_in) begin
      state_next_s = HOLD;
      cnt_next_s   = '0;
    end else if ((state_r == RELEASE || state_r == RUN) && !lock_s) begin
      state_next_s = HOLD;
      cnt_next_s   = '0;
      loss_s       = 1'b1;
    end else begin
      case (state_r)
        HOLD: begin
          if (cnt_r == STRETCH_END) begin
            state_next_s = WAIT_LOCK;
            cnt_next_s   = '0;
          end else begin
            cnt_next_s = cnt_r + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next_s = FILTER;
            cnt_next_s   = '0;
          end else begin
            cnt_next_s = '0;
          end
        end
        FILTER: begin
          if (!lock_s) begin
            state_next_s = WAIT_LOCK;
            cnt_next_s   = '0;
          end else if (cnt_r == FILTER_END) begin
            state_next_s = (REL_LAST == 0) ? RUN : RELEASE;
            cnt_next_s   = '0;
          end else begin
            cnt_next_s = cnt_r + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_r == RELEASE_END) begin
            state_next_s = RUN;
            cnt_next_s   = '0;
          end else begin
            cnt_next_s = cnt_r + 1'b1;
          end
        end
        RUN: begin
          cnt_next_s = '0;
        end
        default: begin
          state_next_s = HOLD;
          cnt_next_s   = '0;
        end
      endcase
    end

    for (int i = 0; i < NUM_DOMAINS; i++) begin
      rst_next_s[i] = ~((state_next_s == RUN) ||
                        ((state_next_s == RELEASE) && (32'(cnt_next_s) >= 32'(i * STAGGER_CYCLES))));
    end
  end

  // Sequencer state and outputs, registered from the next-state decode.
  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r        <= HOLD;
      cnt_r          <= '0;
      domain_rst_out <= '1;
      locked         <= 1'b0;
      lock_lost      <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      cnt_r          <= cnt_next_s;
      domain_rst_out <= rst_next_s;
      locked         <= (state_next_s == RUN);
      if (soft_rst_in) begin
        lock_lost <= 1'b0;
      end else if (loss_s) begin
        lock_lost <= 1'b1;
      end
    end
  end

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  // Saturating count of lock losses seen after release started.
  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      loss_count <= '0;
    end else if (soft_rst_in) begin
      loss_count <= '0;
    end else if (loss_s && (loss_count != {LOSS_CNT_W{1'b1}})) begin
      loss_count <= loss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with a phase/age reference model.
module tb_pll_reset_sequencer;

  localparam int N  = 3;
  localparam int SS = 2;
  localparam int S  = 4;
  localparam int F  = 8;
  localparam int G  = 2;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  localparam int LW = 8;
`endif
  localparam int MAX_LOSS = 255;

  logic         clock_in    = 1'b0;
  logic         rst_n_in    = 1'b1;
  logic         pll_lock_in = 1'b0;
  logic         soft_rst_in = 1'b0;
  logic [N-1:0] domain_rst_out;
  logic         locked;
  logic         lock_lost;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  logic [LW-1:0] loss_count;
`endif

  int tests = 0;
  int fails = 0;

  // Model: phase 0 stretch, 1 await lock, 2 qualify, 3 released (staggered then running).
  int          cyc;
  int          m_phase;
  int          m_since;
  logic [SS-1:0] m_sync;
  logic        m_lost;
  int          m_losses;

  pll_reset_sequencer #(
    .NUM_DOMAINS        (N),
    .SYNC_STAGES        (SS),
    .STRETCH_CYCLES     (S),
    .LOCK_FILTER_CYCLES (F),
    .STAGGER_CYCLES     (G)
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    , .LOSS_CNT_W       (LW)
`endif
  ) dut (
    .clock_in       (clock_in),
    .rst_n_in       (rst_n_in),
    .pll_lock_in    (pll_lock_in),
    .soft_rst_in    (soft_rst_in),
    .domain_rst_out (domain_rst_out),
    .locked         (locked),
    .lock_lost      (lock_lost)
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    , .loss_count   (loss_count)
`endif
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc      = 0;
    m_phase  = 0;
    m_since  = 0;
    m_sync   = '0;
    m_lost   = 1'b0;
    m_losses = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int   age;
    int   nc;
    logic ls;
    if (!rst_n_in) begin
      model_reset();
    end else begin
      ls  = m_sync[SS-1];
      age = cyc - m_since;
      nc  = cyc + 1;
      if (soft_rst_in) begin
        m_phase = 0; m_since = nc; m_lost = 1'b0; m_losses = 0;
      end else begin
        case (m_phase)
          0: if (age >= S - 1) begin m_phase = 1; m_since = nc; end
          1: if (ls) begin m_phase = 2; m_since = nc; end
          2: begin
            if (!ls) begin
              m_phase = 1; m_since = nc;
            end else if (age >= F - 1) begin
              m_phase = 3; m_since = nc;
            end
          end
          3: if (!ls) begin
            m_phase = 0; m_since = nc; m_lost = 1'b1;
            if (m_losses < MAX_LOSS) m_losses++;
          end
          default: ;
        endcase
      end
      cyc    = nc;
      m_sync = {m_sync[SS-2:0], pll_lock_in};
    end
  endtask

  task automatic cmp_model();
    int         age;
    logic [N-1:0] er;
    age = cyc - m_since;
    for (int i = 0; i < N; i++) er[i] = !(m_phase == 3 && age >= i * G);
    check("model_rst", domain_rst_out, er);
    check("model_locked", locked, (m_phase == 3 && age >= (N - 1) * G));
    check("model_lost", lock_lost, m_lost);
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    check("model_cnt", loss_count, m_losses);
`endif
  endtask

  // One clock: model follows the edge, DUT is compared on the falling edge.
  task automatic tick();
    @(posedge clock_in);
    model_step();
    @(negedge clock_in);
    cmp_model();
  endtask

  // Current period number at a falling edge is cyc+1.
  task automatic run_to(input int p);
    for (int k = 0; k < 1000 && cyc + 1 < p; k++) tick();
    check("run_to_period", cyc + 1, p);
  endtask

  task automatic release_reset();
    repeat (2) tick();
    rst_n_in = 1'b1;
  endtask

  task automatic wait_released();
    for (int k = 0; k < 200 && m_phase != 3; k++) tick();
    check("wait_release_bound", m_phase, 3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rst"}, domain_rst_out, 3'b111);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_lost"}, lock_lost, 1'b0);
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    check({tag, "_cnt"}, loss_count, 8'd0);
`endif
  endtask

  initial begin
    #1 rst_n_in = 1'b0;
    pll_lock_in = 1'b1;
    model_reset();
    #1 check_reset_values("por");

    // Lock stable high across reset release.
    release_reset();
    run_to(13); check("p13_rst", domain_rst_out, 3'b111);
    run_to(14); check("p14_rst", domain_rst_out, 3'b110);
    run_to(15); check("p15_rst", domain_rst_out, 3'b110);
    run_to(16); check("p16_rst", domain_rst_out, 3'b100);
    run_to(17); check("p17_locked", locked, 1'b0);
    run_to(18); check("p18_rst", domain_rst_out, 3'b000);
    check("p18_locked", locked, 1'b1);
    check("p18_lost", lock_lost, 1'b0);

    // Lock rises at period 20 and glitches low for one sample during FILTER.
    rst_n_in = 1'b0; pll_lock_in = 1'b0; model_reset();
    release_reset();
    run_to(20); pll_lock_in = 1'b1;
    run_to(25); pll_lock_in = 1'b0;
    run_to(26); pll_lock_in = 1'b1;
    run_to(31); check("glitch_no_early_release", domain_rst_out, 3'b111);
    run_to(36); check("glitch_p36_rst", domain_rst_out, 3'b111);
    run_to(37); check("glitch_p37_rst", domain_rst_out, 3'b110);
    check("glitch_lost", lock_lost, 1'b0);

    // Lock lost in RUN, then recovers and the sequence repeats.
    run_to(41); check("run_locked", locked, 1'b1);
    run_to(42); pll_lock_in = 1'b0;
    run_to(44); check("loss_p44_locked", locked, 1'b1);
    run_to(45); check("loss_p45_rst", domain_rst_out, 3'b111);
    check("loss_p45_locked", locked, 1'b0);
    check("loss_p45_lost", lock_lost, 1'b1);
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    check("loss_p45_cnt", loss_count, 8'd1);
`endif
    run_to(50); pll_lock_in = 1'b1;
    run_to(60); check("relock_p60_rst", domain_rst_out, 3'b111);
    run_to(61); check("relock_p61_rst", domain_rst_out, 3'b110);
    check("relock_p61_lost", lock_lost, 1'b1);

    // Asynchronous reset in the middle of RELEASE.
    run_to(62);
    #2 rst_n_in = 1'b0;
    model_reset();
    #1 check_reset_values("async");

    // Soft reset held for three edges in RUN after a recorded loss.
    release_reset();
    run_to(20); pll_lock_in = 1'b0;
    run_to(21); pll_lock_in = 1'b1;
    run_to(23); check("soft_pre_lost", lock_lost, 1'b1);
    run_to(40); check("soft_pre_locked", locked, 1'b1);
    run_to(42); soft_rst_in = 1'b1;
    run_to(43); check_reset_values("soft_p43");
    run_to(45); soft_rst_in = 1'b0;
    run_to(57); check("soft_p57_rst", domain_rst_out, 3'b111);
    run_to(58); check("soft_p58_rst", domain_rst_out, 3'b110);

    // Repeated losses drive the counter into saturation.
    for (int n = 0; n < 300; n++) begin
      wait_released();
      pll_lock_in = 1'b0;
      tick();
      pll_lock_in = 1'b1;
      repeat (4) tick();
    end
    check("sat_lost", lock_lost, 1'b1);
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    check("sat_cnt", loss_count, 8'd255);
`endif

    // Soft reset coincides with a lock loss: soft reset wins.
    wait_released();
    repeat (6) tick();
    check("coinc_locked", locked, 1'b1);
    pll_lock_in = 1'b0;
    tick();
    pll_lock_in = 1'b1;
    tick();
    soft_rst_in = 1'b1;
    tick();
    soft_rst_in = 1'b0;
    check_reset_values("coinc");
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
